// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: default data width,
// error-counter width, the data word type, FIFO control states and a
// saturating-increment helper for the diagnostic counters.
package uart_pkg;

  localparam int BIT_WIDTH = 8;
  localparam int ERR_W     = 8;

  typedef logic [BIT_WIDTH-1:0] data_t;
  typedef logic [ERR_W-1:0]     err_t;

  // Control state of the receive FIFO, implied by its occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } fifo_state_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic err_t sat_inc(input err_t v);
    return (&v) ? v : v + err_t'(1);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Valid/ready stream carrying received bytes from the FIFO to its consumer.
interface uart_rx_fifo_if #(
  parameter int BIT_WIDTH = 8
) ();

  logic [BIT_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  // FIFO side: presents data, observes backpressure.
  modport master (output m_data, output m_valid, input m_ready);
  // Consumer side.
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x BIT_WIDTH register array: one synchronous write port and one
// combinational read port. Storage is not reset.
module uart_fifo_mem #(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [BIT_WIDTH-1:0]     wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [BIT_WIDTH-1:0]     rdata
);

  logic [BIT_WIDTH-1:0] mem [DEPTH];

  // Write port.
  // NOTE: storage has no reset; validity is tracked by the level counter,
  // so clearing the array would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver. Good frames enter a
// first-word-fall-through FIFO drained over a valid/ready stream; bad
// frames and overruns are dropped. Optional diagnostics (sticky overflow
// flag and saturating frame-error / overrun counters) are built only when
// UART_RX_FIFO_ERR_CNT_EN is defined; otherwise those outputs read 0.
module uart_rx_fifo #(
  parameter int BIT_WIDTH = uart_pkg::BIT_WIDTH,
  parameter int DEPTH     = 16,
  parameter int ERR_W     = uart_pkg::ERR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [BIT_WIDTH-1:0]     rx_byte,
  input  logic                     rx_strobe,
  input  logic                     rx_ok,
  uart_rx_fifo_if.master           m_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [ERR_W-1:0]         frame_err_cnt,
  output logic [ERR_W-1:0]         overrun_cnt
);

  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  fifo_state_e   state;
  logic          full;
  logic          push;
  logic          pop;

  // Decode the control state from the occupancy counter.
  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state = ST_PARTIAL;
    if (level == '0)               state = ST_EMPTY;
    else if (level == LW'(DEPTH))  state = ST_FULL;
  end

  assign full           = (state == ST_FULL);
  assign m_if.m_valid   = (state != ST_EMPTY);
  assign pop            = m_if.m_valid & m_if.m_ready;
  assign push           = rx_strobe & rx_ok & (~full | pop);

  // Pointers and occupancy; clr wins over push and pop.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  uart_fifo_mem #(
    .BIT_WIDTH (BIT_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~clr),
    .waddr (wr_ptr),
    .wdata (rx_byte),
    .raddr (rd_ptr),
    .rdata (m_if.m_data)
  );

`ifdef UART_RX_FIFO_ERR_CNT_EN
  logic frame_err;
  logic overrun;

  assign frame_err = rx_strobe & ~rx_ok;
  assign overrun   = rx_strobe & rx_ok & full & ~pop;

  // Diagnostics: sticky overflow flag and saturating error counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow      <= 1'b0;
      frame_err_cnt <= '0;
      overrun_cnt   <= '0;
    end else if (clr) begin
      overflow      <= 1'b0;
      frame_err_cnt <= '0;
      overrun_cnt   <= '0;
    end else begin
      if (frame_err) frame_err_cnt <= sat_inc(frame_err_cnt);
      if (overrun) begin
        overrun_cnt <= sat_inc(overrun_cnt);
        overflow    <= 1'b1;
      end
    end
  end
`else
  assign overflow      = 1'b0;
  assign frame_err_cnt = '0;
  assign overrun_cnt   = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a hand-computed vector table,
// directed corner sequences and a randomized run against a queue model.
module tb_uart_rx_fifo;

  import uart_pkg::*;

  localparam int DEPTH   = 16;
  localparam int BW      = 8;
  localparam int EW      = 8;
  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int ERR_MAX = (1 << EW) - 1;
`ifdef UART_RX_FIFO_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic [BW-1:0] rx_byte;
  logic          rx_strobe;
  logic          rx_ok;
  logic [LW-1:0] level;
  logic          overflow;
  logic [EW-1:0] frame_err_cnt;
  logic [EW-1:0] overrun_cnt;

  uart_rx_fifo_if #(.BIT_WIDTH(BW)) m_if ();

  uart_rx_fifo #(
    .BIT_WIDTH (BW),
    .DEPTH     (DEPTH),
    .ERR_W     (EW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .rx_byte       (rx_byte),
    .rx_strobe     (rx_strobe),
    .rx_ok         (rx_ok),
    .m_if          (m_if),
    .level         (level),
    .overflow      (overflow),
    .frame_err_cnt (frame_err_cnt),
    .overrun_cnt   (overrun_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a byte queue plus counters, advanced once per clock.
  data_t m_q[$];
  int    m_fe;
  int    m_ov;
  bit    m_oflow;

  task automatic model_reset();
    m_q.delete();
    m_fe    = 0;
    m_ov    = 0;
    m_oflow = 0;
  endtask

  task automatic model_clock(input bit c, input bit s, input bit ok, input data_t b, input bit rdy);
    bit was_full;
    bit popped;
    if (c) begin
      model_reset();
      return;
    end
    was_full = (m_q.size() == DEPTH);
    popped   = (m_q.size() != 0) && rdy;
    if (ERR_EN && s && !ok && m_fe < ERR_MAX) m_fe++;
    if (ERR_EN && s && ok && was_full && !popped) begin
      if (m_ov < ERR_MAX) m_ov++;
      m_oflow = 1;
    end
    if (popped) void'(m_q.pop_front());
    if (s && ok && (!was_full || popped)) m_q.push_back(b);
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic cyc(input bit c, input bit s, input bit ok, input data_t b, input bit rdy);
    clr         = c;
    rx_strobe   = s;
    rx_ok       = ok;
    rx_byte     = b;
    m_if.m_ready = rdy;
    model_clock(c, s, ok, b, rdy);
    @(posedge clk);
    #1;
    clr       = 1'b0;
    rx_strobe = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_level"}, 32'(level), 32'(m_q.size()));
    check({tag, "_valid"}, 32'(m_if.m_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check({tag, "_data"}, 32'(m_if.m_data), 32'(m_q[0]));
    check({tag, "_fe"}, 32'(frame_err_cnt), 32'(m_fe));
    check({tag, "_ov"}, 32'(overrun_cnt), 32'(m_ov));
    check({tag, "_oflow"}, 32'(overflow), 32'(m_oflow));
  endtask

  typedef struct {
    bit    c;
    bit    s;
    bit    ok;
    data_t b;
    bit    rdy;
    bit    exp_valid;
    int    exp_level;
    data_t exp_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // Hand-computed walk from an empty FIFO.
    vecs[0] = '{c:0, s:1, ok:1, b:8'hA5, rdy:0, exp_valid:1, exp_level:1, exp_data:8'hA5};
    vecs[1] = '{c:0, s:1, ok:1, b:8'h11, rdy:0, exp_valid:1, exp_level:2, exp_data:8'hA5};
    vecs[2] = '{c:0, s:1, ok:0, b:8'h22, rdy:0, exp_valid:1, exp_level:2, exp_data:8'hA5};
    vecs[3] = '{c:0, s:0, ok:0, b:8'h00, rdy:1, exp_valid:1, exp_level:1, exp_data:8'h11};
    vecs[4] = '{c:0, s:1, ok:1, b:8'h33, rdy:1, exp_valid:1, exp_level:1, exp_data:8'h33};
    vecs[5] = '{c:0, s:0, ok:0, b:8'h00, rdy:0, exp_valid:1, exp_level:1, exp_data:8'h33};
    vecs[6] = '{c:1, s:1, ok:1, b:8'h44, rdy:1, exp_valid:0, exp_level:0, exp_data:8'h00};
    vecs[7] = '{c:0, s:1, ok:1, b:8'h55, rdy:1, exp_valid:1, exp_level:1, exp_data:8'h55};
    vecs[8] = '{c:0, s:0, ok:0, b:8'h00, rdy:1, exp_valid:0, exp_level:0, exp_data:8'h00};

    rst          = 1'b1;
    clr          = 1'b0;
    rx_byte      = '0;
    rx_strobe    = 1'b0;
    rx_ok        = 1'b0;
    m_if.m_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    check("rst_valid", 32'(m_if.m_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_oflow", 32'(overflow), 0);
    check("rst_fe", 32'(frame_err_cnt), 0);
    check("rst_ov", 32'(overrun_cnt), 0);

    // First byte after reset appears the next cycle.
    cyc(0, 1, 1, 8'hA5, 0);
    check("first_valid", 32'(m_if.m_valid), 1);
    check("first_data", 32'(m_if.m_data), 32'h A5);
    check("first_level", 32'(level), 1);

    // Vector table.
    cyc(1, 0, 0, 8'h00, 0);
    foreach (vecs[i]) begin
      cyc(vecs[i].c, vecs[i].s, vecs[i].ok, vecs[i].b, vecs[i].rdy);
      check($sformatf("vec%0d_valid", i), 32'(m_if.m_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_data", i), 32'(m_if.m_data), 32'(vecs[i].exp_data));
    end

    // Overrun: fill, strobe 0xFF while full, drain 0x00..0x0F.
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 1, data_t'(i), 0);
    check("ovr_full_level", 32'(level), DEPTH);
    cyc(0, 1, 1, 8'hFF, 0);
    check("ovr_level", 32'(level), DEPTH);
    check("ovr_cnt", 32'(overrun_cnt), ERR_EN ? 1 : 0);
    check("ovr_flag", 32'(overflow), ERR_EN ? 1 : 0);
    check("ovr_fe", 32'(frame_err_cnt), 0);
    m_if.m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("ovr_drain%0d", i), 32'(m_if.m_data), 32'(i));
      cyc(0, 0, 0, 8'h00, 1);
    end
    check("ovr_drained", 32'(m_if.m_valid), 0);
    check("ovr_flag_sticky", 32'(overflow), ERR_EN ? 1 : 0);

    // Push and pop together at FULL.
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 1, data_t'(i), 0);
    cyc(0, 1, 1, 8'h55, 1);
    check("pp_level", 32'(level), DEPTH);
    check("pp_ov", 32'(overrun_cnt), 0);
    check("pp_flag", 32'(overflow), 0);
    for (int i = 1; i <= DEPTH; i++) begin
      check($sformatf("pp_drain%0d", i), 32'(m_if.m_data), (i == DEPTH) ? 32'h55 : 32'(i));
      cyc(0, 0, 0, 8'h00, 1);
    end
    check("pp_drained", 32'(m_if.m_valid), 0);

    // Frame errors and counter saturation.
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 1, 0, 8'h3C, 0);
    check("fe_level", 32'(level), 0);
    check("fe_one", 32'(frame_err_cnt), ERR_EN ? 1 : 0);
    for (int i = 1; i < 300; i++) cyc(0, 1, 0, 8'h3C, 0);
    check("fe_sat", 32'(frame_err_cnt), ERR_EN ? ERR_MAX : 0);
    check("fe_sat_level", 32'(level), 0);

    // Asynchronous reset mid-drain, then clr alongside a strobe.
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, data_t'(8'h80 + i), 0);
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 8'h00, 1);
    check("mid_level", 32'(level), 3);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(m_if.m_valid), 0);
    check("arst_level", 32'(level), 0);
    model_reset();
    #1 rst = 1'b0;
    cyc(0, 1, 0, 8'h99, 0);
    cyc(1, 1, 1, 8'h77, 0);
    check("clr_level", 32'(level), 0);
    check("clr_valid", 32'(m_if.m_valid), 0);
    check("clr_fe", 32'(frame_err_cnt), 0);
    check("clr_ov", 32'(overrun_cnt), 0);
    check("clr_flag", 32'(overflow), 0);

    // Randomized run against the queue model.
    for (int n = 0; n < 4000; n++) begin
      bit    c;
      bit    s;
      bit    ok;
      bit    rdy;
      data_t b;
      c   = ($urandom_range(0, 299) == 0);
      s   = ($urandom_range(0, 1) == 0);
      ok  = ($urandom_range(0, 7) != 0);
      rdy = (n < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      b   = data_t'($urandom);
      cyc(c, s, ok, b, rdy);
      check_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each byte the receiver reports together with its one-cycle completion strobe and stop-bit status. Good frames are queued in a first-word-fall-through FIFO drained through a valid/ready interface. Bad frames and overruns are dropped and counted for diagnostics.

## Interface
- BIT_WIDTH, 8: data width; equals the receiver's BIT_WIDTH.
- DEPTH, 16: FIFO entries; power of two, ≥ 2.
- ERR_W, 8: width of each error counter.

- clk  input  1  system clock; same domain as the receiver.
- rst  input  1  reset; asynchronous, active-high.
- clr  input  1  synchronous flush: empties the FIFO and clears counters and the sticky flag.
- rx_byte  input  BIT_WIDTH  receiver data; sampled only when rx_strobe=1.
- rx_strobe  input  1  one-cycle pulse: frame complete.
- rx_ok  input  1  stop bit seen high; qualifies rx_strobe.
- m_data  output  BIT_WIDTH  head-of-queue byte.
- m_valid  output  1  queue non-empty.
- m_ready  input  1  consumer accepts m_data when m_valid=1.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a good frame was dropped because the FIFO was full.
- frame_err_cnt  output  ERR_W  saturating count of frames with rx_ok=0.
- overrun_cnt  output  ERR_W  saturating count of good frames dropped while full.

## Operation
- Push condition: rx_strobe & rx_ok & (!full | pop). Store rx_byte at wr_ptr, then advance wr_ptr.
- Pop condition: m_valid & m_ready. Advance rd_ptr.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- level is a separate counter: +1 on push only, −1 on pop only, unchanged on both or neither.
- full = (level==DEPTH); m_valid = (level!=0); m_data = mem[rd_ptr] (combinational read of registered storage).
- Frame error: rx_strobe & !rx_ok. The byte is discarded and frame_err_cnt increments.
- Overrun: rx_strobe & rx_ok & full & !pop. The byte is discarded, overrun_cnt increments and overflow is set.
- Counters saturate at 2^ERR_W−1 and never wrap.
- Control states are implied by level:
  - EMPTY (level=0)
  - PARTIAL
  - FULL (level=DEPTH)
  - Transitions occur only on push/pop as above.
- clr has priority over push, pop and error events in the same cycle. After clr: level=0, pointers 0, counters 0, overflow 0. Storage contents are don't-care.

## Timing
- Reset values: m_valid=0, level=0, overflow=0, both counters 0, pointers 0. m_data is don't-care while m_valid=0.
- Reset mid-operation discards all queued data immediately (asynchronous).
- Latency: a strobe accepted in cycle N gives m_valid=1 and m_data=rx_byte in cycle N+1.
- Push at EMPTY with m_ready=1: no pop in cycle N because m_valid=0.
- Push and pop in the same cycle at FULL: both take effect, level stays DEPTH, no overrun.
- Push and pop in the same cycle at PARTIAL: level unchanged, head advances.
- m_data and m_valid must hold stable while m_valid=1 & m_ready=0.
- Error counters and overflow update one cycle after the triggering strobe.
- Sustained throughput: one pop per cycle. The receiver strobes at most once per frame time.

## Configuration
- UART_RX_FIFO_ERR_CNT_EN defined: frame_err_cnt, overrun_cnt and overflow are implemented as above.
- Not defined:
  - All three outputs are tied to 0 and no counter flops are generated.
  - Bad frames and overruns are still dropped identically.
  - FIFO behaviour is unchanged.

## Structure
- The shared package uart_pkg holds:
  - default BIT_WIDTH
  - ERR_W
  - a typedef for the data word
  - a helper function for saturating increment
- One sub-module, uart_fifo_mem: DEPTH×BIT_WIDTH register array with one write port and one combinational read port, no reset on storage.
- Pointer, level, flag and counter logic stays in uart_rx_fifo.

## Test plan
- After reset, strobe 0xA5 with rx_ok=1 and m_ready=0. Next cycle: m_valid=1, m_data=0xA5, level=1.
- Push 16 bytes 0x00..0x0F, then strobe 0xFF with m_ready=0. Required: level=16, overrun_cnt=1, overflow=1. Drain order 0x00..0x0F; 0xFF never appears.
- FIFO full and m_ready=1 while strobing 0x55. Required: level stays 16, no overrun, 0x55 is the last byte drained.
- Strobe 0x3C with rx_ok=0. Required: level unchanged, frame_err_cnt=1. Repeat 300 times: frame_err_cnt saturates at 255.
- Fill with 5 bytes, assert rst for 1 cycle mid-drain. Required: m_valid=0, level=0 asynchronously. Then pulse clr alongside a strobe: the FIFO stays empty and counters read 0.
- Build without UART_RX_FIFO_ERR_CNT_EN and repeat the overflow scenario. Required: counters and overflow stay 0, and drained data is identical to the enabled build.
